// File: rtl/temporal_bitgen_border.sv
// Border-stage temporal-unary generator. It turns a registered sign/magnitude
// operand into a window of 2^(WIDTH-1) cycles in which the first |x| bits are 1.
module temporal_bitgen_border #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             i_data_sign,
  input  logic [WIDTH-2:0] i_data_abs,
  output logic             o_en,
  output logic             o_bit,
  output logic             o_sign,
  output logic             o_last,
  output logic             o_done
);

  localparam int unsigned MW  = WIDTH - 1;
  localparam int unsigned LEN = 1 << MW;
  localparam logic [MW-1:0] CNT_LAST = MW'(LEN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e          state_q;
  logic            sign_q;
  logic [MW-1:0]   abs_q;
  logic [MW-1:0]   cnt_q;
  logic            done_q;

  logic            last_c;
  logic            load_c;

  // Final window cycle; a new operand may be taken here with no bubble.
  assign last_c  = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  assign i_ready = !clr && ((state_q == ST_IDLE) || last_c);
  assign load_c  = i_valid && i_ready;

  // Control and datapath registers; abort has priority over load and count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      abs_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_c) begin
        state_q <= ST_RUN;
        sign_q  <= i_data_sign;
        abs_q   <= i_data_abs;
        cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
        if (last_c) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          done_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + MW'(1);
        end
      end
    end
  end

  // Stream outputs are pure decodes of registered state.
  assign o_en   = (state_q == ST_RUN);
  assign o_bit  = (state_q == ST_RUN) && (cnt_q < abs_q);
  assign o_sign = sign_q;
  assign o_last = last_c;
  assign o_done = done_q;

endmodule

// File: tb/tb_temporal_bitgen_border.sv
// Bench for temporal_bitgen_border: queue-based window model checked every cycle,
// plus directed scenarios with literal ones-count / timing expectations.
module tb_temporal_bitgen_border;

  localparam int WIDTH = 8;
  localparam int LEN   = 128;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             i_valid;
  logic             i_ready;
  logic             i_data_sign;
  logic [WIDTH-2:0] i_data_abs;
  logic             o_en;
  logic             o_bit;
  logic             o_sign;
  logic             o_last;
  logic             o_done;

  temporal_bitgen_border #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_data_sign(i_data_sign),
    .i_data_abs (i_data_abs),
    .o_en       (o_en),
    .o_bit      (o_bit),
    .o_sign     (o_sign),
    .o_last     (o_last),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic b;
    logic last;
  } ent_t;

  // Model: every accepted operand enqueues its whole expected window.
  ent_t q[$];
  logic m_sign   = 1'b0;
  logic m_done   = 1'b0;
  bit   started  = 1'b0;
  int   cyc      = 0;
  logic was_last;
  logic ld;
  ent_t e;

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (rst || clr) begin
      q.delete();
      m_sign = 1'b0;
      m_done = 1'b0;
    end else begin
      was_last = 1'b0;
      ld = i_valid && (q.size() <= 1);
      if (q.size() > 0) begin
        was_last = q[0].last;
        void'(q.pop_front());
      end
      if (ld) begin
        m_sign = i_data_sign;
        for (int k = 0; k < LEN; k++) begin
          e.b    = (k < int'(i_data_abs));
          e.last = (k == LEN - 1);
          q.push_back(e);
        end
      end
      m_done = was_last && !ld;
    end
  end

  // Per-window observations used by the literal checks.
  int win_ones[$];
  int win_len[$];
  int ones_acc = 0;
  int len_acc  = 0;
  int n_done   = 0;
  int last_cyc = 0;
  int done_cyc = 0;

  logic x_rdy, x_en, x_bit, x_last;

  always @(negedge clk) begin
    if (started) begin
      x_rdy  = !clr && (q.size() <= 1);
      x_en   = (q.size() > 0);
      x_bit  = x_en ? q[0].b : 1'b0;
      x_last = x_en ? q[0].last : 1'b0;
      n_vec++;
      if (i_ready !== x_rdy || o_en !== x_en || o_bit !== x_bit ||
          o_sign !== m_sign || o_last !== x_last || o_done !== m_done) begin
        n_err++;
        $display("FAIL stream cyc=%0d act rdy,en,bit,sign,last,done=%b%b%b%b%b%b req=%b%b%b%b%b%b",
                 cyc, i_ready, o_en, o_bit, o_sign, o_last, o_done,
                 x_rdy, x_en, x_bit, m_sign, x_last, m_done);
      end
      if (o_en === 1'b1) begin
        ones_acc += int'(o_bit);
        len_acc++;
        if (o_last === 1'b1) begin
          win_ones.push_back(ones_acc);
          win_len.push_back(len_acc);
          last_cyc = cyc;
          ones_acc = 0;
          len_acc  = 0;
        end
      end else begin
        ones_acc = 0;
        len_acc  = 0;
      end
      if (o_done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic s, input int a);
    i_valid     = 1'b1;
    i_data_sign = s;
    i_data_abs  = (WIDTH-1)'(a);
    tick();
    i_valid     = 1'b0;
    i_data_abs  = (WIDTH-1)'($urandom);
    i_data_sign = 1'($urandom);
  endtask

  task automatic run_single(input string name, input logic s, input int a, input int req_ones);
    int nd0;
    nd0 = n_done;
    load(s, a);
    settle();
    check({name, "_sign"}, int'(o_sign), int'(s));
    repeat (130) tick();
    settle();
    check({name, "_ones"}, win_ones[$], req_ones);
    check({name, "_len"}, win_len[$], LEN);
    check({name, "_done"}, n_done - nd0, 1);
    check({name, "_done_gap"}, done_cyc - last_cyc, 1);
  endtask

  task automatic wait_last(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_last === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic abort_case(input string name, input bit use_rst);
    int nd0;
    int nw0;
    nd0 = n_done;
    nw0 = win_ones.size();
    load(1'b1, 50);
    repeat (39) tick();
    if (use_rst) rst = 1'b1;
    else         clr = 1'b1;
    i_valid     = 1'b1;
    i_data_sign = 1'b1;
    i_data_abs  = 7'd9;
    tick();
    rst     = 1'b0;
    clr     = 1'b0;
    i_valid = 1'b0;
    settle();
    check({name, "_en"}, int'(o_en), 0);
    check({name, "_ready"}, int'(i_ready), 1);
    check({name, "_sign"}, int'(o_sign), 0);
    check({name, "_last"}, int'(o_last), 0);
    repeat (5) tick();
    settle();
    check({name, "_no_window"}, win_ones.size() - nw0, 0);
    check({name, "_no_done"}, n_done - nd0, 0);
    check({name, "_idle"}, int'(o_en), 0);
  endtask

  initial begin
    bit ok;
    int nd0;
    rst         = 1'b1;
    clr         = 1'b0;
    i_valid     = 1'b0;
    i_data_sign = 1'b0;
    i_data_abs  = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    settle();
    check("idle_ready", int'(i_ready), 1);
    check("idle_en", int'(o_en), 0);
    check("idle_bit", int'(o_bit), 0);
    check("idle_done", int'(o_done), 0);

    run_single("abs5", 1'b0, 5, 5);
    run_single("abs0_neg", 1'b1, 0, 0);
    run_single("abs127", 1'b0, 127, 127);

    // Back-to-back: valid held, second operand taken on the last cycle.
    nd0 = n_done;
    i_valid     = 1'b1;
    i_data_sign = 1'b0;
    i_data_abs  = 7'd3;
    tick();
    i_data_sign = 1'b1;
    i_data_abs  = 7'd100;
    wait_last(ok);
    check("b2b_last_seen", int'(ok), 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    settle();
    check("b2b_sign2", int'(o_sign), 1);
    repeat (130) tick();
    settle();
    check("b2b_ones1", win_ones[$-1], 3);
    check("b2b_ones2", win_ones[$], 100);
    check("b2b_len2", win_len[$], LEN);
    check("b2b_done", n_done - nd0, 1);

    // Valid pulsed mid-window must be ignored.
    load(1'b0, 20);
    repeat (10) tick();
    i_valid     = 1'b1;
    i_data_sign = 1'b1;
    i_data_abs  = 7'd9;
    settle();
    check("hold_ready", int'(i_ready), 0);
    tick();
    i_valid = 1'b0;
    repeat (130) tick();
    settle();
    check("hold_ones", win_ones[$], 20);
    check("hold_len", win_len[$], LEN);

    abort_case("clr_abort", 1'b0);
    abort_case("rst_abort", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
